// File: rtl/ser_pkg.sv
// Shared constants for the N:1 serializer cell: default idle word,
// PRBS7 taps and seed, and the legal WIDTH range check.
package ser_pkg;

  localparam logic [63:0] IDLE_WORD_DEF = 64'h1E1E5;

  localparam int PRBS_TAP_HI = 6;
  localparam int PRBS_TAP_LO = 5;
  localparam logic [6:0] PRBS_SEED = 7'h7F;

  function automatic bit width_ok(int w);
    return (w >= 2) && (w <= 64);
  endfunction

endpackage

// File: rtl/ser_nto1_cell_prbs.sv
// PRBS7 generator, x^7+x^6+1, seeded to all ones on reset.
// Advances one step on every enabled CP edge.
module prbs7_gen
  import ser_pkg::*;
(
  input  logic CP,
  input  logic CDN,
  input  logic EN,
  output logic Q
);

  logic [6:0] lfsr_q;
  logic [6:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (EN) begin
      lfsr_d = {lfsr_q[5:0],
                lfsr_q[PRBS_TAP_HI] ^ lfsr_q[PRBS_TAP_LO]};
    end
  end

  always_ff @(posedge CP or negedge CDN) begin
    if (!CDN) lfsr_q <= PRBS_SEED;
    else      lfsr_q <= lfsr_d;
  end

  assign Q = lfsr_q[6];

endmodule

// File: rtl/ser_nto1_cell.sv
// N:1 serializer with shadow register and idle-word insertion.
// Optional PRBS7 test output compiled in with SER_NTO1_PRBS_EN.
module ser_nto1_cell
  import ser_pkg::*;
#(
  parameter int               WIDTH     = 20,
  parameter bit               MSB_FIRST = 1'b1,
  parameter logic [WIDTH-1:0] IDLE_WORD = WIDTH'(IDLE_WORD_DEF)
) (
  input  logic             CP,
  input  logic             CDN,
  input  logic             EN,
  input  logic [WIDTH-1:0] D,
  input  logic             VALID,
  output logic             READY,
  input  logic             CLR_UNDERFLOW,
  input  logic             TEST_PRBS,
  output logic             Q,
  output logic             FRAME,
  output logic             UNDERFLOW
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);
  localparam bit WIDTH_LEGAL = width_ok(WIDTH);

  if (!WIDTH_LEGAL) begin : g_width_illegal
    $error("ser_nto1_cell: WIDTH must be 2..64");
  end

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             shf_q, shf_d;
  logic             frame_q, frame_d;
  logic             und_q, und_d;
  logic             bnd;
  logic             xfer;
  logic             und_set;
  logic             q_sr;

  assign bnd     = EN & (cnt_q == CNT_MAX);
  assign READY   = ~shf_q | bnd;
  assign xfer    = VALID & READY;
  assign und_set = bnd & ~shf_q;
  assign q_sr    = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];

  always_comb begin
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    if (EN) begin
      cnt_d   = bnd ? '0 : cnt_q + CW'(1);
      frame_d = bnd;
      if (!bnd) begin
        sr_d = MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);
      end else if (shf_q) begin
        sr_d = sh_q;
      end else begin
        sr_d = IDLE_WORD;
      end
    end
  end

  // A refill on the same edge that drains the shadow keeps it full.
  always_comb begin
    sh_d  = sh_q;
    shf_d = shf_q;
    if (xfer) begin
      sh_d  = D;
      shf_d = 1'b1;
    end else if (bnd) begin
      shf_d = 1'b0;
    end
  end

  always_comb begin
    und_d = und_q;
    if (und_set)            und_d = 1'b1;
    else if (CLR_UNDERFLOW) und_d = 1'b0;
  end

  always_ff @(posedge CP or negedge CDN) begin
    if (!CDN) begin
      sr_q    <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      shf_q   <= 1'b0;
      frame_q <= 1'b0;
      und_q   <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      shf_q   <= shf_d;
      frame_q <= frame_d;
      und_q   <= und_d;
    end
  end

  assign UNDERFLOW = und_q;

`ifdef SER_NTO1_PRBS_EN
  logic prbs_bit;

  prbs7_gen u_prbs (
    .CP  (CP),
    .CDN (CDN),
    .EN  (EN),
    .Q   (prbs_bit)
  );

  assign Q     = TEST_PRBS ? prbs_bit : q_sr;
  assign FRAME = frame_q & ~TEST_PRBS;
`else
  logic unused_test_prbs;
  assign unused_test_prbs = TEST_PRBS;

  assign Q     = q_sr;
  assign FRAME = frame_q;
`endif

endmodule
